// File: rtl/amiga_bus.sv
`timescale 1ns/1ps
// amiga_bus: runs a 68000-style Amiga bus cycle on behalf of a 68030 cycle marked external.
// Latency: AS asserts on the first synchronised CLK7M rise after AS20; the ack follows the fall7 that samples DTACK low.
// Backpressure: none internally; the 68030 is held off by withholding DSACK1/BERR20 until the 68000 cycle is acknowledged.
// Ports: CLKCPU/RESET clock and async active-low reset; CLK7M, DTACK asynchronous Amiga inputs;
//        AS20/DS20/RW20/SIZ/A0/INTCYCLE from the 68030 side; AS/UDS/LDS/RW to the 68000 bus;
//        DSACK1/BERR20 back to the 68030; LATCH read-data capture pulse; WOE write buffer enable.
module amiga_bus #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       CLK7M,
  input  logic       AS20,
  input  logic       DS20,
  input  logic       RW20,
  input  logic [1:0] SIZ,
  input  logic       A0,
  input  logic       INTCYCLE,
  input  logic       DTACK,
  output logic       AS,
  output logic       UDS,
  output logic       LDS,
  output logic       RW,
  output logic       DSACK1,
  output logic       BERR20,
  output logic       LATCH,
  output logic       WOE
);

  typedef enum logic [2:0] {IDLE, SYNC, S2, S4, WAIT_DTACK, ACK, S7, HOLD} state_t;

  state_t     state_q, state_d;
  logic       c7_meta_q, c7_sync_q, c7_prev_q;
  logic       dt_meta_q, dt_sync_q;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] siz_q, siz_d;
  logic       a0_q, a0_d, rw20_q, rw20_d, abort_q, abort_d;
  logic       as_q, as_d, uds_q, uds_d, lds_q, lds_d, rw_q, rw_d;
  logic       dsack_q, dsack_d, berr_q, berr_d, latch_q, latch_d, woe_q, woe_d;
  logic       rise7, fall7, sel_u, sel_l, timeout_hit;
  logic [7:0] cnt_inc;
  logic       unused_ds20;

  // Data strobes are qualified by AS20 on the 68030 side, so DS20 carries no extra information here.
  assign unused_ds20 = DS20;

  assign rise7 = c7_sync_q & ~c7_prev_q;
  assign fall7 = ~c7_sync_q & c7_prev_q;

  // Upper byte lane is used only for even addresses; lower lane for odd addresses or any multi-byte size.
  assign sel_u = ~a0_q;
  assign sel_l = a0_q | (siz_q != 2'b01);

  assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timeout_hit = dt_sync_q && (cnt_inc >= TIMEOUT);

  // State register, synchronisers and registered outputs.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      c7_meta_q <= 1'b1;
      c7_sync_q <= 1'b1;
      c7_prev_q <= 1'b1;
      dt_meta_q <= 1'b1;
      dt_sync_q <= 1'b1;
      cnt_q     <= 8'd0;
      siz_q     <= 2'b00;
      a0_q      <= 1'b0;
      rw20_q    <= 1'b1;
      abort_q   <= 1'b0;
      as_q      <= 1'b1;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      rw_q      <= 1'b1;
      dsack_q   <= 1'b1;
      berr_q    <= 1'b1;
      latch_q   <= 1'b0;
      woe_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      c7_meta_q <= CLK7M;
      c7_sync_q <= c7_meta_q;
      c7_prev_q <= c7_sync_q;
      dt_meta_q <= DTACK;
      dt_sync_q <= dt_meta_q;
      cnt_q     <= cnt_d;
      siz_q     <= siz_d;
      a0_q      <= a0_d;
      rw20_q    <= rw20_d;
      abort_q   <= abort_d;
      as_q      <= as_d;
      uds_q     <= uds_d;
      lds_q     <= lds_d;
      rw_q      <= rw_d;
      dsack_q   <= dsack_d;
      berr_q    <= berr_d;
      latch_q   <= latch_d;
      woe_q     <= woe_d;
    end
  end

  // Next state, wait counter, captured request attributes and abort tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    siz_d   = siz_q;
    a0_d    = a0_q;
    rw20_d  = rw20_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (!AS20 && INTCYCLE) begin
          state_d = SYNC;
          cnt_d   = 8'd0;
          siz_d   = SIZ;
          a0_d    = A0;
          rw20_d  = RW20;
          abort_d = 1'b0;
        end
      end
      SYNC: begin
        if (AS20)       state_d = IDLE;
        else if (rise7) state_d = S2;
      end
      S2: begin
        if (AS20)  abort_d = 1'b1;
        if (fall7) state_d = S4;
      end
      S4: begin
        if (AS20) abort_d = 1'b1;
        state_d = WAIT_DTACK;
      end
      WAIT_DTACK: begin
        if (AS20) abort_d = 1'b1;
        if (fall7) begin
          if (!dt_sync_q) begin
            state_d = ACK;
          end else begin
            cnt_d = cnt_inc;
            if (timeout_hit) state_d = ACK;
          end
        end
      end
      ACK:     if (fall7) state_d = S7;
      S7:      state_d = HOLD;
      HOLD:    if (AS20) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values, keyed on the transition being taken.
  always_comb begin
    as_d    = as_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    rw_d    = rw_q;
    dsack_d = dsack_q;
    berr_d  = berr_q;
    latch_d = latch_q;
    woe_d   = woe_q;
    case (state_q)
      SYNC: begin
        if (state_d == S2) begin
          as_d = 1'b0;
          rw_d = rw20_q;
          if (rw20_q) begin
            uds_d = ~sel_u;
            lds_d = ~sel_l;
          end else begin
            woe_d = 1'b0;
          end
        end
      end
      S2: begin
        // Write data strobes wait half a 7M period so the data buffer has settled.
        if (state_d == S4 && !rw20_q) begin
          uds_d = ~sel_u;
          lds_d = ~sel_l;
        end
      end
      WAIT_DTACK: begin
        // AS20 seen high on this very edge still counts as an abort.
        if (state_d == ACK && !(abort_q || AS20)) begin
          if (dt_sync_q)   berr_d  = 1'b0;
          else if (rw20_q) latch_d = 1'b1;
          else             dsack_d = 1'b0;
        end
      end
      ACK: begin
        // Read data is captured one cycle before the 68030 is told it is valid.
        if (latch_q) begin
          latch_d = 1'b0;
          dsack_d = 1'b0;
        end
        if (state_d == S7) begin
          as_d  = 1'b1;
          uds_d = 1'b1;
          lds_d = 1'b1;
          woe_d = 1'b1;
        end
      end
      HOLD: begin
        if (state_d == IDLE) begin
          dsack_d = 1'b1;
          berr_d  = 1'b1;
          rw_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign AS     = as_q;
  assign UDS    = uds_q;
  assign LDS    = lds_q;
  assign RW     = rw_q;
  assign DSACK1 = dsack_q;
  assign BERR20 = berr_q;
  assign LATCH  = latch_q;
  assign WOE    = woe_q;

endmodule

// File: tb/tb_amiga_bus.sv
`timescale 1ns/1ps
// tb_amiga_bus: drives 68030-style requests and an Amiga-style DTACK responder around amiga_bus.
// Latency: expectations are counted in raw CLK7M falling edges and CLKCPU samples.
// Backpressure: the bench plays the 68030, holding AS20 low until an ack is seen.
module tb_amiga_bus;

  localparam int TMO = 200;

  logic       CLKCPU = 1'b0;
  logic       RESET = 1'b0;
  logic       CLK7M = 1'b1;
  logic       AS20 = 1'b1;
  logic       DS20 = 1'b1;
  logic       RW20 = 1'b1;
  logic [1:0] SIZ = 2'b10;
  logic       A0 = 1'b0;
  logic       INTCYCLE = 1'b1;
  logic       DTACK = 1'b1;
  logic       AS, UDS, LDS, RW, DSACK1, BERR20, LATCH, WOE;

  int errors = 0;
  int checks = 0;
  int f7_cnt = 0;

  amiga_bus #(.TIMEOUT(8'd200)) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .CLK7M(CLK7M), .AS20(AS20), .DS20(DS20),
    .RW20(RW20), .SIZ(SIZ), .A0(A0), .INTCYCLE(INTCYCLE), .DTACK(DTACK),
    .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .DSACK1(DSACK1), .BERR20(BERR20),
    .LATCH(LATCH), .WOE(WOE)
  );

  // 50 MHz CPU clock; ~7.14 MHz Amiga clock whose edges never meet a CPU edge.
  always #10 CLKCPU = ~CLKCPU;
  initial begin
    #5;
    forever #70 CLK7M = ~CLK7M;
  end
  always @(negedge CLK7M) f7_cnt <= f7_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {AS, UDS, LDS, RW, DSACK1, BERR20, WOE, LATCH};
  endfunction

  // Byte lanes {upper, lower} a 68000 transfer of this size and alignment must strobe.
  function automatic logic [1:0] lanes(input logic [1:0] siz, input logic a0);
    if (siz == 2'b01) return a0 ? 2'b01 : 2'b10;
    return a0 ? 2'b01 : 2'b11;
  endfunction

  // One 68030 request. d = raw CLK7M fall (counted from AS assertion) on which DTACK is seen low.
  task automatic run_txn(input logic [1:0] siz, input logic a0, input logic rw,
                         input int d, input bit abrt, input bit tmo);
    int n = 0, as_f = -1, as_f7 = 0, as_r = -1, as_r7 = 0;
    int uds_f = -1, lds_f = -1, woe_f = -1, woe_r = -1, rw_r = -1, rw_at_as = -1;
    int lat_n = -1, lat_cnt = 0, dsk_f = -1, dsk_f7 = 0, dsk_r = -1;
    int brr_f = -1, brr_f7 = 0, brr_r = -1, rel_n = -1, raise_n = -1, end_n = -1, sf;
    bit both = 0, done = 0;
    logic [2:0] strb_at_r = 3'b000;
    logic [1:0] exp_ln;
    logic p_as = 1, p_uds = 1, p_lds = 1, p_woe = 1, p_dsk = 1, p_brr = 1, p_rw = 1;
    exp_ln = lanes(siz, a0);
    repeat ($urandom_range(0, 6)) @(negedge CLKCPU);
    SIZ = siz; A0 = a0; RW20 = rw; INTCYCLE = 1'b1; AS20 = 1'b0;
    while (!done && n < 4000) begin
      @(negedge CLKCPU);
      n++;
      if (p_as && !AS) begin as_f = n; as_f7 = f7_cnt; rw_at_as = RW; end
      if (!p_as && AS) begin as_r = n; as_r7 = f7_cnt; strb_at_r = {UDS, LDS, WOE}; end
      if (p_uds && !UDS) uds_f = n;
      if (p_lds && !LDS) lds_f = n;
      if (p_woe && !WOE) woe_f = n;
      if (!p_woe && WOE) woe_r = n;
      if (!p_rw && RW) rw_r = n;
      if (LATCH) begin lat_cnt++; if (lat_n < 0) lat_n = n; end
      if (p_dsk && !DSACK1) begin dsk_f = n; dsk_f7 = f7_cnt; end
      if (!p_dsk && DSACK1) dsk_r = n;
      if (p_brr && !BERR20) begin brr_f = n; brr_f7 = f7_cnt; end
      if (!p_brr && BERR20) brr_r = n;
      if (!DSACK1 && !BERR20) both = 1;
      // Amiga side: pull DTACK during the high phase before fall d.
      if (!tmo && as_f >= 0 && (f7_cnt - as_f7) >= d - 1 && CLK7M) DTACK = 1'b0;
      if (abrt && as_f >= 0 && !AS20 && (f7_cnt - as_f7) >= 2) begin
        AS20 = 1'b1; raise_n = n;
      end
      if (!abrt && rel_n < 0 && (!DSACK1 || !BERR20)) rel_n = n + $urandom_range(0, 3);
      if (!abrt && !AS20 && rel_n >= 0 && n == rel_n) begin
        chk("ack_held", tmo ? int'(BERR20) : int'(DSACK1), 0);
        AS20 = 1'b1; raise_n = n;
      end
      if (end_n < 0 && as_r >= 0 && raise_n >= 0)
        end_n = (((as_r + 2) > (raise_n + 1)) ? (as_r + 2) : (raise_n + 1)) + 2;
      done = (end_n >= 0 && n >= end_n);
      p_as = AS; p_uds = UDS; p_lds = LDS; p_woe = WOE; p_dsk = DSACK1; p_brr = BERR20; p_rw = RW;
    end
    DTACK = 1'b1;
    chk("txn_done", done, 1);
    chk("as_asserted", as_f >= 0, 1);
    chk("uds_lane", uds_f >= 0, exp_ln[1]);
    chk("lds_lane", lds_f >= 0, exp_ln[0]);
    sf = exp_ln[1] ? uds_f : lds_f;
    if (exp_ln == 2'b11) chk("uds_lds_together", uds_f, lds_f);
    if (rw) chk("rd_strobe_delay", sf - as_f, 0);
    else    chk("wr_strobe_half7m", (sf - as_f) inside {3, 4}, 1);
    chk("rw_out", rw_at_as, rw);
    if (rw) chk("woe_read_idle", woe_f, -1);
    else begin
      chk("woe_on_at_as", woe_f, as_f);
      chk("woe_off_at_s7", woe_r, as_r);
      chk("rw_release", rw_r, end_n - 2);
    end
    chk("strobes_negate_s7", strb_at_r, 3'b111);
    chk("dsack_berr_overlap", both, 0);
    if (abrt) begin
      chk("abort_latch", lat_cnt, 0);
      chk("abort_dsack", dsk_f, -1);
      chk("abort_berr", brr_f, -1);
      chk("abort_as_end_f7", as_r7 - as_f7, d + 1);
    end else if (tmo) begin
      chk("tmo_berr_f7", brr_f7 - as_f7, TMO + 1);
      chk("tmo_no_dsack", dsk_f, -1);
      chk("tmo_as_end_f7", as_r7 - as_f7, TMO + 2);
      chk("tmo_berr_release", brr_r, end_n - 2);
    end else begin
      chk("ack_f7", dsk_f7 - as_f7, d);
      if (rw) begin
        chk("latch_pulses", lat_cnt, 1);
        chk("dsack_after_latch", dsk_f, lat_n + 1);
      end else begin
        chk("wr_no_latch", lat_cnt, 0);
      end
      chk("as_end_f7", as_r7 - as_f7, d + 1);
      chk("dsack_release", dsk_r, end_n - 2);
      chk("no_berr", brr_f, -1);
    end
  endtask

  initial begin
    int k, b;
    repeat (3) @(negedge CLKCPU);
    chk("reset_outs", outs(), 8'hFE);
    RESET = 1'b1;
    repeat (4) @(negedge CLKCPU);
    chk("idle_outs", outs(), 8'hFE);

    run_txn(2'b10, 1'b0, 1'b1, 3, 1'b0, 1'b0);   // word read
    run_txn(2'b01, 1'b1, 1'b0, 3, 1'b0, 1'b0);   // byte write, odd
    run_txn(2'b10, 1'b0, 1'b1, 0, 1'b0, 1'b1);   // DTACK never comes
    run_txn(2'b10, 1'b0, 1'b1, 5, 1'b1, 1'b0);   // 68030 gives up in WAIT_DTACK

    // Internal cycle: the Amiga bus must not move.
    INTCYCLE = 1'b0; AS20 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLKCPU);
      if (i % 8 == 7) chk("intcycle_idle", outs(), 8'hFE);
    end
    AS20 = 1'b1;
    repeat (2) @(negedge CLKCPU);
    INTCYCLE = 1'b1;

    // Reset in the middle of WAIT_DTACK.
    SIZ = 2'b10; A0 = 1'b0; RW20 = 1'b1; AS20 = 1'b0;
    k = 0;
    while (AS && k < 200) begin @(negedge CLKCPU); k++; end
    chk("rst_test_as_low", AS, 0);
    b = f7_cnt; k = 0;
    while ((f7_cnt - b) < 2 && k < 200) begin @(negedge CLKCPU); k++; end
    #3 RESET = 1'b0;
    #2 chk("rst_async_outs", outs(), 8'hFE);
    @(negedge CLKCPU);
    AS20 = 1'b1;
    repeat (3) @(negedge CLKCPU);
    RESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLKCPU);
      if (i % 5 == 4) chk("post_rst_idle", outs(), 8'hFE);
    end
    run_txn(2'b11, 1'b1, 1'b1, 2, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      logic [1:0] s;
      logic a, r;
      bit ab;
      s  = 2'($urandom_range(0, 3));
      a  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 4) == 0);
      run_txn(s, a, r, ab ? int'($urandom_range(4, 7)) : int'($urandom_range(2, 6)), ab, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
